// File: rtl/io_timer_sched.sv
// io_timer_sched: shares the 40-bit FRC among NSLOT one-shot deadline slots and
// raises a round-robin arbitrated machine-timer interrupt with a readable slot ID.
module io_timer_sched #(
    parameter int          NSLOT    = 4,
    parameter logic [13:0] BASE_ADR = 14'h3E10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_io_we,
    input  logic [13:0] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [13:0] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    input  logic [39:0] frc_val,
    input  logic        frc_run,
    input  logic        csr_mtie,
    output logic        timer_irq
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    localparam logic [7:0] SMASK = 8'((1 << NSLOT) - 1);
    localparam logic [3:0] NS    = 4'(NSLOT);

    // Slot state is held at the 8-slot maximum; bits above NSLOT never get set.
    logic [39:0] cmp_q [8];
    logic [7:0]  en_q, en_d, armed_q, armed_d, pend_q, pend_d, req;
    logic [2:0]  ptr_q, last_q, id_q, gnt, wi, ri;
    logic [3:0]  idx;
    state_t      state_q;
    logic        irq_q, hit_q, hit, match;
    logic        w_slot, w_lo, w_hi, w_ctrl, w_pend, r_slot;
    logic [31:0] rdata_q, rd;
    logic [13:0] woff, roff;

    assign woff   = dma_io_wadr - BASE_ADR;
    assign roff   = dma_io_radr - BASE_ADR;
    assign wi     = woff[3:1];
    assign ri     = roff[3:1];
    assign w_slot = dma_io_we && woff < 14'd16 && {1'b0, wi} < NS;
    assign w_lo   = w_slot && !woff[0];
    assign w_hi   = w_slot && woff[0];
    assign w_ctrl = dma_io_we && woff == 14'd16;
    assign w_pend = dma_io_we && woff == 14'd17;
    assign r_slot = roff < 14'd16 && {1'b0, ri} < NS;
    assign hit    = r_slot || (roff >= 14'd16 && roff <= 14'd18);

    // A write to the slot under the scanner blocks its match this cycle.
    assign match = frc_run && armed_q[ptr_q] && en_q[ptr_q] &&
                   frc_val >= cmp_q[ptr_q] && !(w_slot && wi == ptr_q);

    always_comb begin
        armed_d = armed_q;
        if (w_lo) armed_d[wi] = 1'b0;
        if (w_hi) armed_d[wi] = 1'b1;
        if (match) armed_d[ptr_q] = 1'b0;
        en_d   = w_ctrl ? dma_io_wdata[7:0] & SMASK : en_q;
        pend_d = (pend_q & ~(w_pend ? dma_io_wdata[7:0] : 8'h0)) |
                 (match ? 8'h1 << ptr_q : 8'h0);
    end

    assign req = pend_q & en_q;

    // Descending scan so the nearest slot after last_grant is the one kept.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NSLOT; i >= 1; i--) begin
            idx = {1'b0, last_q} + 4'(i);
            idx = idx >= NS ? idx - NS : idx;
            if (req[idx[2:0]]) gnt = idx[2:0];
        end
    end

    assign rd = r_slot ? (roff[0] ? {24'h0, cmp_q[ri][39:32]} : cmp_q[ri][31:0]) :
                roff == 14'd16 ? {8'h0, armed_q, 8'h0, en_q} :
                roff == 14'd17 ? {24'h0, pend_q} :
                {state_q == ACTIVE, 28'h0, id_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) cmp_q[i] <= '0;
            en_q    <= '0;
            armed_q <= '0;
            pend_q  <= '0;
            ptr_q   <= '0;
            last_q  <= '0;
            id_q    <= '0;
            state_q <= IDLE;
            irq_q   <= 1'b0;
            hit_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (w_lo) cmp_q[wi][31:0] <= dma_io_wdata;
            if (w_hi) cmp_q[wi][39:32] <= dma_io_wdata[7:0];
            en_q    <= en_d;
            armed_q <= armed_d;
            pend_q  <= pend_d;
            if (frc_run) ptr_q <= ptr_q == 3'(NSLOT - 1) ? 3'd0 : ptr_q + 3'd1;
            if (state_q == IDLE) begin
                if (|req) begin
                    state_q <= ACTIVE;
                    id_q    <= gnt;
                end
            end else if (!en_d[id_q]) begin
                state_q <= IDLE;
            end else if (!pend_d[id_q]) begin
                state_q <= IDLE;
                last_q  <= id_q;
            end
            irq_q <= state_q == ACTIVE && csr_mtie;
            if (dma_io_radr_en) begin
                hit_q <= hit;
                if (hit) rdata_q <= rd;
            end
        end
    end

    assign timer_irq    = irq_q;
    assign dma_io_rdata = hit_q ? rdata_q : dma_io_rdata_in;
endmodule

// File: tb/tb_io_timer_sched.sv
// tb_io_timer_sched: directed scenarios plus randomized deadlines checked
// against latency windows derived from the slot-scan rules.
module tb_io_timer_sched;
    localparam int          NSLOT = 4;
    localparam logic [13:0] BASE  = 14'h3E10;

    logic        clk = 0, rst_n = 0, we = 0, radr_en = 0, frc_run = 0, mtie = 1, ramp = 0;
    logic [13:0] wadr = 0, radr = 0;
    logic [31:0] wdata = 0, rdata, rv;
    logic [31:0] rdin = 32'hC0DE_1234;
    logic [39:0] frc = 0;
    logic        irq, irq_at;
    int          total = 0, bad = 0, sp = 0, first;

    always #5 clk = ~clk;

    // Scan position as the spec describes it: one step per running cycle.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) sp <= 0;
        else if (frc_run) sp <= (sp == NSLOT - 1) ? 0 : sp + 1;

    io_timer_sched #(.NSLOT(NSLOT), .BASE_ADR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .dma_io_we(we), .dma_io_wadr(wadr),
        .dma_io_wdata(wdata), .dma_io_radr(radr), .dma_io_radr_en(radr_en),
        .dma_io_rdata_in(rdin), .dma_io_rdata(rdata), .frc_val(frc),
        .frc_run(frc_run), .csr_mtie(mtie), .timer_irq(irq)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        if (ramp) frc = frc + 40'd1;
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        wadr  = BASE + 14'(off);
        wdata = d;
        we    = 1;
        tick;
        we    = 0;
    endtask

    task automatic rda(input logic [13:0] a, output logic [31:0] d);
        radr    = a;
        radr_en = 1;
        tick;
        radr_en = 0;
        d       = rdata;
    endtask

    task automatic rdo(input int off, output logic [31:0] d);
        rda(BASE + 14'(off), d);
    endtask

    // Poll PEND every cycle; stops at the first nonzero value.
    task automatic poll(input int n, output int fst, output logic ia, output logic [31:0] v);
        radr    = BASE + 14'd17;
        radr_en = 1;
        fst     = -1;
        ia      = 0;
        v       = 0;
        for (int i = 1; i <= n; i++) begin
            tick;
            if (rdata != 0) begin
                fst = i;
                ia  = irq;
                v   = rdata;
                break;
            end
        end
        radr_en = 0;
    endtask

    task automatic grant_step(input logic [31:0] m, input logic [2:0] nid);
        wr(17, m);
        chk("gs_irq_hold", irq, 1);
        tick;
        chk("gs_irq_gap", irq, 0);
        tick;
        chk("gs_irq_back", irq, 1);
        rdo(18, rv);
        chk("gs_id", rv, {1'b1, 28'h0, nid});
    endtask

    initial begin
        int          s, d, lo, hi, guard;
        logic [39:0] base, cmp;
        logic        ok;
        tick;
        tick;
        chk("rst_irq", irq, 0);
        chk("rst_rdata_pass", rdata, rdin);
        rst_n = 1;
        rdo(16, rv); chk("rst_ctrl", rv, 0);
        rdo(17, rv); chk("rst_pend", rv, 0);
        rdo(18, rv); chk("rst_id", rv, 0);
        rdo(0, rv);  chk("rst_cmplo0", rv, 0);

        // slot0 deadline 0x100 with FRC ramping from 0xF0
        frc_run = 1;
        frc     = 40'hF0;
        wr(0, 32'h100);
        wr(1, 0);
        wr(16, 1);
        ramp = 1;
        rdo(17, rv); chk("t1_early_pend", rv, 0);
        guard = 0;
        while (frc != 40'h100 && guard < 64) begin tick; guard++; end
        chk("t1_ramp_reached", frc, 40'h100);
        poll(NSLOT + 2, first, irq_at, rv);
        chk("t1_latency_ok", first >= 2 && first <= NSLOT + 1, 1);
        chk("t1_pend", rv, 1);
        chk("t1_irq_at_active", irq_at, 0);
        tick;
        chk("t1_irq_next", irq, 1);
        rdo(18, rv); chk("t1_id", rv, 32'h8000_0000);
        rdo(16, rv); chk("t1_ctrl_disarmed", rv, 32'h0000_0001);
        wr(17, 1);
        chk("t1_irq_w1c_edge", irq, 1);
        tick;
        chk("t1_irq_drop", irq, 0);
        ramp = 0;

        // half-written deadline must not fire until CMPHI is written
        frc = 40'h80;
        wr(2, 32'h50);
        wr(16, 2);
        poll(8, first, irq_at, rv);
        chk("t2_no_pend_unarmed", first, -1);
        wr(3, 0);
        poll(NSLOT + 2, first, irq_at, rv);
        chk("t2_latency_ok", first >= 2 && first <= NSLOT + 1, 1);
        chk("t2_pend", rv, 2);
        chk("t2_irq_at_active", irq_at, 0);
        tick;
        chk("t2_irq_next", irq, 1);
        rdo(18, rv); chk("t2_id", rv, 32'h8000_0001);
        wr(17, 2);
        tick;
        tick;

        // establish last_grant = 0, then pend 0/2/3 and check grant order 2,3,0
        wr(0, 0); wr(1, 0);
        wr(16, 1);
        repeat (6) tick;
        rdo(18, rv); chk("t3_id0", rv, 32'h8000_0000);
        wr(17, 1);
        tick;
        tick;
        wr(0, 0); wr(1, 0); wr(4, 0); wr(5, 0); wr(6, 0); wr(7, 0);
        wr(16, 13);
        repeat (8) tick;
        rdo(17, rv); chk("t3_pend_all", rv, 13);
        wr(16, 0);
        tick;
        tick;
        chk("t3_irq_masked", irq, 0);
        rdo(17, rv); chk("t3_pend_kept", rv, 13);
        wr(16, 13);
        tick;
        tick;
        chk("t3_irq_first", irq, 1);
        rdo(18, rv); chk("t3_id_first", rv, 32'h8000_0002);
        grant_step(4, 3);
        grant_step(8, 0);
        wr(17, 1);
        chk("t3_last_irq_hold", irq, 1);
        tick;
        chk("t3_last_irq_drop", irq, 0);
        tick;
        chk("t3_last_irq_stay", irq, 0);
        rdo(18, rv); chk("t3_id_idle", rv, 0);

        // W1C on pend1 in the very cycle slot1 matches: set wins
        wr(16, 0);
        wr(2, 0); wr(3, 0);
        guard = 0;
        while (sp != 0 && guard < 8) begin tick; guard++; end
        chk("t4_align", sp, 0);
        wr(16, 2);
        wr(17, 2);
        mtie = 0;
        rdo(17, rv); chk("t4_set_wins", rv, 2);
        tick;
        tick;
        chk("t4_mtie_off", irq, 0);
        mtie = 1;
        tick;
        chk("t4_mtie_on", irq, 1);
        wr(17, 2);
        tick;
        tick;

        // halted scanner, unmapped reads
        frc_run = 0;
        wr(16, 1);
        wr(0, 0); wr(1, 0);
        repeat (8) tick;
        rdo(17, rv); chk("t5_halt_no_pend", rv, 0);
        rdo(16, rv); chk("t5_ctrl_armed", rv, 32'h0001_0001);
        rdo(20, rv); chk("t5_unmapped_hi", rv, rdin);
        rda(BASE - 14'd1, rv); chk("t5_unmapped_lo", rv, rdin);
        rdo(8, rv);  chk("t5_unmapped_slot", rv, rdin);

        // reset while ACTIVE
        frc_run = 1;
        repeat (8) tick;
        chk("t6_irq_active", irq, 1);
        rdo(18, rv); chk("t6_id_active", rv, 32'h8000_0000);
        #2 rst_n = 0;
        #1;
        chk("t6_irq_async", irq, 0);
        chk("t6_rdata_pass", rdata, rdin);
        frc_run = 0;
        tick;
        tick;
        rst_n = 1;
        rdo(16, rv); chk("t6_ctrl", rv, 0);
        rdo(17, rv); chk("t6_pend", rv, 0);
        rdo(18, rv); chk("t6_id", rv, 0);
        rdo(1, rv);  chk("t6_cmphi0", rv, 0);

        // randomized deadlines, including carries across the 32-bit word
        for (int r = 0; r < 12; r++) begin
            s    = $urandom_range(0, NSLOT - 1);
            d    = $urandom_range(0, 40);
            base = {8'($urandom_range(0, 254)),
                    (r % 2 == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : 32'($urandom)};
            cmp  = base + 40'(d);
            frc_run = 0;
            ramp    = 0;
            frc     = base;
            wr(16, 0);
            wr(17, 32'hFF);
            wr(2 * s, cmp[31:0]);
            wr(2 * s + 1, {24'h0, cmp[39:32]});
            rdo(2 * s, rv);     chk("rnd_cmplo", rv, cmp[31:0]);
            rdo(2 * s + 1, rv); chk("rnd_cmphi", rv, {24'h0, cmp[39:32]});
            wr(16, 32'(1) << s);
            frc_run = 1;
            ramp    = 1;
            lo = d + 2;
            hi = d + NSLOT + 1;
            poll(30, first, irq_at, rv);
            ok = (first < 0) ? (hi > 30) : (first >= lo && first <= hi && rv == (32'(1) << s));
            chk("rnd_deadline", ok, 1);
        end
        ramp    = 0;
        frc_run = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_timer_sched.md
Name: io_timer_sched

Overview:
- Multi-channel timer scheduler that shares the single 40-bit free-run counter (FRC) among NSLOT software deadline slots.
- Each slot holds a one-shot 40-bit deadline. A sequential scanner compares one slot per cycle against the live FRC value and latches per-slot pending bits.
- A round-robin arbiter presents one pending slot at a time as a single machine-timer interrupt with a readable slot ID.
- Sits on the IO bus next to the FRC block and drives the CPU timer interrupt line.

Parameters:
- NSLOT, 4, number of deadline slots; legal range 1..8.
- BASE_ADR, 14'h3E10, word address of slot 0 CMPLO; map is relative to this base.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- dma_io_we  in  1  IO write strobe
- dma_io_wadr  in  14  IO write word address [15:2]
- dma_io_wdata  in  32  IO write data
- dma_io_radr  in  14  IO read word address [15:2]
- dma_io_radr_en  in  1  IO read strobe
- dma_io_rdata_in  in  32  read data chained from upstream IO blocks
- dma_io_rdata  out  32  read data, this block or pass-through
- frc_val  in  40  current FRC count
- frc_run  in  1  FRC running; scanner halts when low
- csr_mtie  in  1  machine timer interrupt enable from CSR
- timer_irq  out  1  registered interrupt request

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. All of the following clear to 0: cmp slots, en, armed, pend, scan pointer, irq FSM, last_grant, id, timer_irq, read-hit flag, rdata register.
- Address map, word addresses relative to BASE_ADR:
  - +2n: CMPLO slot n, bits [31:0].
  - +2n+1: CMPHI slot n, data [7:0] gives bits [39:32].
  - +16: CTRL. RW en[NSLOT-1:0]. Armed bits read-only at [16+NSLOT-1:16].
  - +17: PEND. Read pend[NSLOT-1:0]; write 1 to clear.
  - +18: ID. Read-only: bit31 = active, [2:0] = granted slot.
  - Unused bits read 0.
- Arming:
  - Write CMPLO n: updates low word, clears armed[n]. This prevents a half-written deadline from firing.
  - Write CMPHI n: updates high byte, sets armed[n].
  - A write to slot n suppresses any match of slot n in that same cycle.
- Scanner:
  - ptr advances 0..NSLOT-1 and wraps, one step per cycle while frc_run=1. It holds while frc_run=0.
  - Match condition: armed[ptr] & en[ptr] & (frc_val >= cmp[ptr]), 40-bit unsigned.
  - On match: pend[ptr] set, armed[ptr] cleared (one-shot).
  - Worst-case detection latency from deadline reached to pend set is NSLOT cycles.
  - Clearing en[n] does not clear pend[n], but a disabled slot is masked from arbitration.
- Pending conflicts: match-set and W1C on the same bit in the same cycle resolve as set wins.
- IRQ FSM, states IDLE and ACTIVE:
  - IDLE: if any (pend & en) is set, grant the first set bit searching upward from last_grant+1 with wrap. Latch id and go to ACTIVE on the next cycle.
  - ACTIVE: stay while pend[id] = 1. When pend[id] is cleared (W1C), set last_grant = id and return to IDLE. A re-grant is possible no earlier than 1 cycle later.
  - ACTIVE: if en[id] is cleared, also return to IDLE. last_grant is unchanged.
- timer_irq is registered: next value = (state==ACTIVE) & csr_mtie. It deasserts the cycle after the W1C of the granted bit.
- Read path:
  - On dma_io_radr_en with an address hit, register the data and a hit flag; data appears the following cycle.
  - dma_io_rdata = hit_q ? rdata_q : dma_io_rdata_in, combinational.
  - Non-hit reads clear hit_q.
- Address decoding uses dma_io_wadr for writes and dma_io_radr for reads. Addresses outside the map are ignored.
- Reset mid-operation: all pending and armed state is lost and timer_irq drops asynchronously.

Test Plan:
- Program slot0 = 40'h00_0000_0100, en=4'b0001, frc_val ramps from 0xF0 with frc_run=1 -> pend[0] set within 4 cycles after frc_val reaches 0x100. timer_irq=1 one cycle after FSM enters ACTIVE. ID reads 0x8000_0000. armed[0] reads 0.
- Write CMPLO slot1 only (0x50), en=2, frc_val=0x80 -> no pend (not armed). Then write CMPHI=0 -> pend[1] set within 4 cycles.
- Slots 0, 2 and 3 all pending, last_grant=0 -> grants in order 2, 3, 0 across successive W1C writes. timer_irq drops for exactly 1 cycle between grants.
- W1C to pend[1] in the same cycle the scanner matches slot1 -> pend[1] stays 1. csr_mtie=0 with ACTIVE state -> timer_irq=0; raising csr_mtie gives timer_irq=1 next cycle.
- frc_run=0 with a past deadline armed -> no pend. Read of an unmapped address returns dma_io_rdata_in. Assert rst_n low while ACTIVE -> timer_irq=0 immediately, all registers read 0 after release.
